// File: rtl/digit_counter.sv
// digit_counter: up/down hex digit (BCD when DIGIT_COUNTER_DECIMAL_EN) with prescaler tick, synchronised step, load and wrap
module digit_counter #(
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] compare,
  input  logic                  run,
  input  logic                  up,
  input  logic                  step,
  input  logic                  load,
  input  logic [3:0]            load_value,
  output logic [3:0]            digit,
  output logic                  wrap,
  output logic                  tick
);
`ifdef DIGIT_COUNTER_DECIMAL_EN
  localparam logic [3:0] MAX = 4'd9;
  logic [3:0] load_clamped;
  assign load_clamped = (load_value > MAX) ? MAX : load_value;
`else
  localparam logic [3:0] MAX = 4'd15;
  logic [3:0] load_clamped;
  assign load_clamped = load_value;
`endif
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [2:0]            sync_q, sync_d;
  logic [3:0]            digit_q, digit_d;
  logic                  wrap_q, wrap_d, tick_q, tick_d;
  logic                  tick_ev, step_ev, count_ev, at_edge;
  // next state: load beats tick/step, which count once even when coincident
  always_comb begin
    tick_ev  = run && (presc_q >= compare);
    step_ev  = sync_q[1] && !sync_q[2];
    count_ev = tick_ev || step_ev;
    at_edge  = up ? (digit_q >= MAX) : (digit_q == 4'd0);
    sync_d   = {sync_q[1:0], step};
    presc_d  = (!run || load || tick_ev) ? '0 : presc_q + 1'b1;
    digit_d  = load ? load_clamped :
               !count_ev ? digit_q :
               at_edge ? (up ? 4'd0 : MAX) :
               up ? digit_q + 4'd1 : digit_q - 4'd1;
    wrap_d   = !load && count_ev && at_edge;
    tick_d   = !load && tick_ev;
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      sync_q  <= '0;
      digit_q <= '0;
      wrap_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sync_q  <= sync_d;
      digit_q <= digit_d;
      wrap_q  <= wrap_d;
      tick_q  <= tick_d;
    end
  end
  assign digit = digit_q;
  assign wrap  = wrap_q;
  assign tick  = tick_q;
endmodule

// File: tb/tb_digit_counter.sv
// tb_digit_counter: scoreboard bench for digit_counter (honours DIGIT_COUNTER_DECIMAL_EN)
module tb_digit_counter;
`ifdef DIGIT_COUNTER_DECIMAL_EN
  localparam logic [3:0] MAX = 4'd9;
  localparam logic [3:0] CLAMP = 4'd9;
`else
  localparam logic [3:0] MAX = 4'd15;
  localparam logic [3:0] CLAMP = 4'd12;
`endif
  typedef struct packed {logic [3:0] d; logic w; logic t;} exp_t;
  logic        clk = 1'b0, reset = 1'b1, run = 1'b0, up = 1'b1, step = 1'b0, load = 1'b0;
  logic [23:0] compare = '0;
  logic [3:0]  load_value = '0;
  logic [3:0]  digit;
  logic        wrap, tick;
  exp_t        sb[$];
  exp_t        e;
  int          vectors = 0, miscompares = 0;

  digit_counter #(.PRESCALE_W(24)) dut (
    .clk(clk), .reset(reset), .compare(compare), .run(run), .up(up), .step(step),
    .load(load), .load_value(load_value), .digit(digit), .wrap(wrap), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic edge_wait;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #3;
    sb.push_back('{4'd0, 1'b0, 1'b0});
    e = sb.pop_front();
    vectors++;
    if ({digit, wrap, tick} !== e) begin
      miscompares++;
      $display("FAIL reset: got %0d/%b/%b expected %0d/%b/%b", digit, wrap, tick, e.d, e.w, e.t);
    end
  endtask

  task automatic test_tick_count;
    compare = 24'd3; run = 1'b1; up = 1'b1;
    edge_wait();
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) sb.push_back('{4'(k / 4), 1'b0, (k % 4) == 0});
    for (int k = 1; k <= 12; k++) begin
      edge_wait();
      e = sb.pop_front();
      vectors++;
      if ({digit, wrap, tick} !== e) begin
        miscompares++;
        $display("FAIL tick_count edge %0d: got %0d/%b/%b expected %0d/%b/%b", k, digit, wrap, tick, e.d, e.w, e.t);
      end
    end
  endtask

  task automatic test_step;
    logic [6:0] ld = 7'b0000001, st = 7'b0000111;
    logic [3:0] ed [7] = '{4'd4, 4'd4, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5};
    run = 1'b0; up = 1'b1; load_value = 4'd4;
    for (int i = 0; i < 7; i++) begin
      load = ld[i];
      step = (i > 0) && st[i-1];
      sb.push_back('{ed[i], 1'b0, 1'b0});
      edge_wait();
      e = sb.pop_front();
      vectors++;
      if ({digit, wrap, tick} !== e) begin
        miscompares++;
        $display("FAIL step cycle %0d: got %0d/%b/%b expected %0d/%b/%b", i, digit, wrap, tick, e.d, e.w, e.t);
      end
    end
    step = 1'b0;
  endtask

  task automatic test_wrap;
    logic [6:0] ld = 7'b0100001, rn = 7'b1001010, u = 7'b0000111;
    logic [3:0] lv [7] = '{MAX, 4'd0, 4'd0, 4'd0, 4'd0, 4'd12, 4'd0};
    exp_t ex [7] = '{'{MAX, 1'b0, 1'b0}, '{4'd0, 1'b1, 1'b1}, '{4'd0, 1'b0, 1'b0},
                     '{MAX, 1'b1, 1'b1}, '{MAX, 1'b0, 1'b0}, '{CLAMP, 1'b0, 1'b0},
                     '{CLAMP - 4'd1, 1'b0, 1'b1}};
    compare = '0;
    for (int i = 0; i < 7; i++) begin
      load = ld[i]; load_value = lv[i]; run = rn[i]; up = u[i];
      sb.push_back(ex[i]);
      edge_wait();
      e = sb.pop_front();
      vectors++;
      if ({digit, wrap, tick} !== e) begin
        miscompares++;
        $display("FAIL wrap cycle %0d: got %0d/%b/%b expected %0d/%b/%b", i, digit, wrap, tick, e.d, e.w, e.t);
      end
    end
    load = 1'b0; run = 1'b0; up = 1'b1;
  endtask

  task automatic test_load;
    logic [3:0] ld = 4'b0001, rn = 4'b0111;
    exp_t ex [4] = '{'{4'd5, 1'b0, 1'b0}, '{4'd6, 1'b0, 1'b1}, '{4'd7, 1'b0, 1'b1}, '{4'd7, 1'b0, 1'b0}};
    compare = '0; up = 1'b1; load_value = 4'd5;
    for (int i = 0; i < 4; i++) begin
      load = ld[i]; run = rn[i];
      sb.push_back(ex[i]);
      edge_wait();
      e = sb.pop_front();
      vectors++;
      if ({digit, wrap, tick} !== e) begin
        miscompares++;
        $display("FAIL load cycle %0d: got %0d/%b/%b expected %0d/%b/%b", i, digit, wrap, tick, e.d, e.w, e.t);
      end
    end
    load = 1'b0; run = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [5:0] ld = 6'b000001, st = 6'b001110, rn = 6'b001000;
    exp_t ex [6] = '{'{4'd2, 1'b0, 1'b0}, '{4'd2, 1'b0, 1'b0}, '{4'd2, 1'b0, 1'b0},
                     '{4'd3, 1'b0, 1'b1}, '{4'd3, 1'b0, 1'b0}, '{4'd3, 1'b0, 1'b0}};
    compare = '0; up = 1'b1; load_value = 4'd2;
    for (int i = 0; i < 6; i++) begin
      load = ld[i]; step = st[i]; run = rn[i];
      sb.push_back(ex[i]);
      edge_wait();
      e = sb.pop_front();
      vectors++;
      if ({digit, wrap, tick} !== e) begin
        miscompares++;
        $display("FAIL coincident cycle %0d: got %0d/%b/%b expected %0d/%b/%b", i, digit, wrap, tick, e.d, e.w, e.t);
      end
    end
    step = 1'b0; run = 1'b0;
  endtask

  task automatic test_reset_mid;
    compare = 24'd3; up = 1'b1; load_value = 4'd7; load = 1'b1; run = 1'b0;
    for (int i = 0; i < 3; i++) sb.push_back('{4'd7, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      load = 1'b0; run = 1'b1;
      e = sb.pop_front();
      vectors++;
      if ({digit, wrap, tick} !== e) begin
        miscompares++;
        $display("FAIL reset_mid pre cycle %0d: got %0d/%b/%b expected %0d/%b/%b", i, digit, wrap, tick, e.d, e.w, e.t);
      end
    end
    #2 reset = 1'b1;
    #1;
    sb.push_back('{4'd0, 1'b0, 1'b0});
    e = sb.pop_front();
    vectors++;
    if ({digit, wrap, tick} !== e) begin
      miscompares++;
      $display("FAIL reset_mid async clear: got %0d/%b/%b expected %0d/%b/%b", digit, wrap, tick, e.d, e.w, e.t);
    end
    edge_wait();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) sb.push_back('{(k == 4) ? 4'd1 : 4'd0, 1'b0, k == 4});
    for (int k = 1; k <= 4; k++) begin
      edge_wait();
      e = sb.pop_front();
      vectors++;
      if ({digit, wrap, tick} !== e) begin
        miscompares++;
        $display("FAIL reset_mid post edge %0d: got %0d/%b/%b expected %0d/%b/%b", k, digit, wrap, tick, e.d, e.w, e.t);
      end
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tick_count();
    test_step();
    test_wrap();
    test_load();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/digit_counter.md
# digit_counter

Up/down single-digit counter that produces the 4-bit value consumed by the 7-segment decoder directly downstream. A programmable prescaler generates the count tick, and a synchronised, edge-detected push-button input allows manual single-stepping. A synchronous load sets the digit directly. A registered wrap pulse allows several instances to be chained into a multi-digit display.

## Interface

Parameters:
- PRESCALE_W, 24, width of prescaler counter and `compare` input.

Ports (clock and reset are single-bit inputs):
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset. The reset polarity and synchronicity are fixed.
- compare  input  PRESCALE_W  tick period minus one; a tick occurs every compare+1 enabled cycles.
- run  input  1  enables the prescaler and automatic counting.
- up  input  1  direction: 1 = increment, 0 = decrement; applies to ticks and steps.
- step  input  1  asynchronous push-button; each rising edge gives one count.
- load  input  1  synchronous load strobe.
- load_value  input  4  value written on load.
- digit  output  4  current count, fed to the 7-segment decoder.
- wrap  output  1  one-cycle pulse when the digit wraps in either direction.
- tick  output  1  one-cycle pulse on every prescaler-generated count.

## Operation

Outputs and reset:
- All outputs are registered. Under reset: digit=0, wrap=0, tick=0, prescaler=0, synchroniser flops=0.

Prescaler:
- While run=0, the prescaler is held at 0 and no tick is produced.
- While run=1, the prescaler increments each cycle. When prescaler ≥ compare, a tick event is raised and the prescaler returns to 0.
- The ≥ comparison makes lowering `compare` below the current count safe.
- compare=0 with run=1 gives a tick every cycle.

Step path:
- 2-flop synchroniser (s1, s2), then a history flop s3.
- Step event = s2 & !s3.
- Step is active regardless of `run`.

Count update (priority order, one action per cycle):
1. load: digit ← load_value (clamped to MAX). Prescaler is restarted at 0. wrap=0, tick=0. A coincident tick or step event is discarded.
2. Tick or step event (either or both): digit moves by exactly one in the `up` direction. A coincident tick and step counts once. tick=1 only if the tick event was present.
3. Otherwise: digit holds, wrap=0, tick=0.

Counting and wrap:
- MAX is 9 or 15 (see Configuration).
- Up: MAX→0 asserts wrap.
- Down: 0→MAX asserts wrap.
- wrap and the wrapped digit appear on the same edge.
- A digit above MAX (possible only via a mode change) is treated as MAX+1 for an up count: next value 0, wrap=1.

## Timing

- Tick latency: with run high from reset release, the first tick and digit change occur at edge compare+1. The next occurs compare+1 edges later.
- Step latency: step rising before edge k → s1 at k, s2 at k+1 → digit changes at edge k+2. Step must stay high ≥2 cycles to be seen, and low ≥2 cycles to re-arm.
- Load latency: digit = load_value after the edge on which load=1 is sampled.
- Reset mid-count: immediate asynchronous clear of all state. A step that was high during reset and is still high after reset is released counts once.

## Configuration

Macro: DIGIT_COUNTER_DECIMAL_EN.
- Defined: MAX=9 (BCD digit). load_value > 9 loads 9.
- Not defined: MAX=15 (hex digit). load_value is loaded unmodified.

## Test plan

- Reset release, compare=3, run=1, up=1 → tick and digit increment at edges 4, 8, 12. digit reaches 1, 2, 3. wrap stays 0.
- Decimal build: load 9, then one tick with up=1 → digit=0, wrap=1 for one cycle. Repeat with up=0 from 0 → digit=9, wrap=1. Hex build: same sequence yields 15/0.
- run=0, step pulse 3 cycles high starting before edge 10 → digit increments exactly once, at edge 12. tick stays 0.
- compare=0, run=1, load=1 with load_value=5 for one cycle → digit=5 after the load edge with no increment. Counting resumes the following cycle: 6, 7, ...
- Tick and step event in the same cycle with digit=2, up=1 → digit=3 (single count), tick=1.
- Reset asserted mid-period (prescaler=2, digit=7) → all outputs 0 immediately. After release with compare=3, the first tick is at edge 4.
